// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;

  // Arbiter FSM: IDLE arbitrates, BURST streams words from one owner.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_MAX_BURST = 4;

  // Bits needed to count from 0 up to max_burst inclusive.
  function automatic int burst_cnt_width(input int max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first set bit of req at or after start, wrapping at N.
// Purely combinational.
module rr_pick #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  // cand[k] is the index examined at priority position k; rot[k] its request.
  logic [IW-1:0] cand [N];
  logic [N-1:0]  rot;

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [IW:0] sum;

    // Modular add of start and the position offset (start is always < N).
    always_comb begin
      sum = {1'b0, start} + (IW+1)'(gi);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      cand[gi] = sum[IW-1:0];
    end

    assign rot[gi] = req[cand[gi]];
  end

  // Lowest rotated position wins; scanning downwards lets it overwrite last.
  always_comb begin
    found = 1'b0;
    idx   = start;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter granting one of NREQ requesters write access to
// a single FIFO. The owner streams up to MAX_BURST words per grant with zero
// latency from request to fifo_wr; an IDLE cycle separates consecutive grants.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST,
  localparam int IW       = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               fifo_wr,
  output logic [DW-1:0]      fifo_data_in,
  input  logic               fifo_full,
  output logic [IW-1:0]      grant_id,
  output logic               busy
);

  localparam int CW = burst_cnt_width(MAX_BURST);

  arb_state_t    state_reg;
  logic [IW-1:0] owner_reg;       // current owner in BURST, last owner in IDLE
  logic [IW-1:0] last_owner_reg;  // round-robin reference point
  logic [CW-1:0] cnt_reg;         // words transferred in the current burst
  logic [DW-1:0] data_hold_reg;   // last word driven to the FIFO

  logic [DW-1:0] word_arr [NREQ];
  logic [IW-1:0] start_idx;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          in_burst;
  logic          owner_valid;
  logic          xfer;
  logic          last_word;

  // Unpack the flat data bus into one word per requester.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
    assign word_arr[gi] = req_data[gi*DW +: DW];
  end

  // Search begins just after the previous owner, wrapping to index 0.
  assign start_idx = (last_owner_reg == IW'(NREQ - 1)) ? '0 : last_owner_reg + 1'b1;

  rr_pick #(
    .N (NREQ)
  ) u_pick (
    .req   (req_valid),
    .start (start_idx),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign in_burst    = (state_reg == BURST);
  assign owner_valid = req_valid[owner_reg];
  assign xfer        = in_burst & owner_valid & ~fifo_full;
  assign last_word   = (cnt_reg == CW'(MAX_BURST - 1));

  // Only the owner sees ready, and only while the FIFO has room. Because the
  // state register resets asynchronously, these drop the instant rst rises.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = in_burst & ~fifo_full & (owner_reg == IW'(gi));
  end

  assign fifo_wr      = xfer;
  assign fifo_data_in = xfer ? word_arr[owner_reg] : data_hold_reg;
  assign grant_id     = owner_reg;
  assign busy         = in_burst;

  // Arbitration FSM, burst counter and held FIFO data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_owner_reg <= IW'(NREQ - 1);
      cnt_reg        <= '0;
      data_hold_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (pick_found) begin
            owner_reg <= pick_idx;
            state_reg <= BURST;
          end
        end
        BURST: begin
          if (xfer) begin
            data_hold_reg <= word_arr[owner_reg];
          end
          if (!owner_valid) begin
            // Owner withdrew: end the burst, keep whatever was already sent.
            state_reg      <= IDLE;
            last_owner_reg <= owner_reg;
            cnt_reg        <= '0;
          end else if (xfer) begin
            if (last_word) begin
              state_reg      <= IDLE;
              last_owner_reg <= owner_reg;
              cnt_reg        <= '0;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
          // Owner valid but FIFO full: hold state and count indefinitely.
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter with a scoreboard of
// per-requester expected word queues and a transaction-level arbitration model.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MB   = 4;
  localparam int IW   = $clog2(NREQ);

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               fifo_wr;
  logic [DW-1:0]      fifo_data_in;
  logic               fifo_full;
  logic [IW-1:0]      grant_id;
  logic               busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_wr      (fifo_wr),
    .fifo_data_in (fifo_data_in),
    .fifo_full    (fifo_full),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // Requester side: words waiting to be sent, and words the FIFO must receive.
  logic [DW-1:0]   src_q [NREQ][$];
  logic [DW-1:0]   exp_q [NREQ][$];
  logic [NREQ-1:0] en;

  // Completed bursts as seen by the model: owner and word count.
  int rec_owner[$];
  int rec_len[$];

  // Model state.
  bit              m_busy;
  int              m_owner;
  int              m_last;
  int              cur_len;
  logic [DW-1:0]   m_data;
  logic [NREQ-1:0] prev_valid;
  int              wr_count;

  function automatic int rr_first(input logic [NREQ-1:0] v, input int s);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(s + k) % NREQ]) return (s + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic push_word(input int i);
    logic [DW-1:0] w;
    w = DW'($urandom);
    src_q[i].push_back(w);
    exp_q[i].push_back(w);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = en[i] && (src_q[i].size() > 0);
      req_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : DW'($urandom);
    end
  endtask

  // One clock: apply inputs, sample acceptance mid-cycle, retire accepted words.
  task automatic tick();
    logic [NREQ-1:0] acc;
    drive();
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
  endtask

  task automatic quiesce();
    en        = '0;
    fifo_full = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < NREQ; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    rec_owner.delete();
    rec_len.delete();
  endtask

  // Monitor: advance the arbitration model one cycle and compare all outputs.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ready;
    bit              exp_wr;
    logic [DW-1:0]   w;
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_fifo_wr", fifo_wr, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_data", fifo_data_in, 0);
      m_busy     = 0;
      m_owner    = 0;
      m_last     = NREQ - 1;
      cur_len    = 0;
      m_data     = '0;
      prev_valid = '0;
      rec_owner.delete();
      rec_len.delete();
    end else begin
      if (!m_busy) begin
        if (prev_valid != 0) begin
          m_owner = rr_first(prev_valid, (m_last + 1) % NREQ);
          m_busy  = 1;
          cur_len = 0;
        end
      end else if (!prev_valid[m_owner] || cur_len == MB) begin
        rec_owner.push_back(m_owner);
        rec_len.push_back(cur_len);
        m_last  = m_owner;
        m_busy  = 0;
        cur_len = 0;
      end
      chk("busy", busy, m_busy);
      chk("grant_id", grant_id, m_owner);
      exp_ready = (m_busy && !fifo_full) ? (NREQ'(1) << m_owner) : '0;
      chk("req_ready", req_ready, exp_ready);
      exp_wr = m_busy && !fifo_full && req_valid[m_owner];
      chk("fifo_wr", fifo_wr, exp_wr);
      if (exp_wr) begin
        if (exp_q[m_owner].size() == 0) begin
          fail_now("unexpected_word");
        end else begin
          w = exp_q[m_owner].pop_front();
          chk("fifo_data", fifo_data_in, w);
          m_data = w;
        end
        cur_len++;
        wr_count++;
        $display("wr req=%0d data=%02h len=%0d", m_owner, fifo_data_in, cur_len);
      end else begin
        chk("data_hold", fifo_data_in, m_data);
      end
      prev_valid = req_valid;
    end
  end

  initial begin
    int budget;
    int wr_before;
    bit all_empty;
    wr_count  = 0;
    rst       = 1'b1;
    en        = '0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (3) tick();
    rst = 1'b0;

    // All four requesters continuously valid: owners 0,1,2,3,0 with 4 words each.
    for (int i = 0; i < NREQ; i++) repeat (8) push_word(i);
    en = '1;
    budget = 0;
    while (rec_owner.size() < 5 && budget < 200) begin tick(); budget++; end
    if (rec_owner.size() < 5) fail_now("t030_timeout");
    else for (int b = 0; b < 5; b++) begin
      chk($sformatf("t030_owner%0d", b), rec_owner[b], b % NREQ);
      chk($sformatf("t030_len%0d", b), rec_len[b], MB);
    end
    quiesce();

    // Only requester 2, ten words: bursts of 4,4,2.
    repeat (10) push_word(2);
    en = 4'b0100;
    budget = 0;
    while (rec_owner.size() < 3 && budget < 200) begin tick(); budget++; end
    if (rec_owner.size() < 3) fail_now("t031_timeout");
    else begin
      chk("t031_owner0", rec_owner[0], 2); chk("t031_len0", rec_len[0], 4);
      chk("t031_owner1", rec_owner[1], 2); chk("t031_len1", rec_len[1], 4);
      chk("t031_owner2", rec_owner[2], 2); chk("t031_len2", rec_len[2], 2);
    end
    quiesce();

    // Owner 1 stalled by fifo_full for three cycles after its second word.
    repeat (4) push_word(1);
    en = 4'b0010;
    budget = 0;
    while (!(m_busy && m_owner == 1 && cur_len == 2) && budget < 50) begin tick(); budget++; end
    if (budget >= 50) fail_now("t032_timeout");
    wr_before = wr_count;
    fifo_full = 1'b1;
    repeat (3) tick();
    chk("t032_stall_writes", wr_count - wr_before, 0);
    chk("t032_stall_busy", busy, 1);
    fifo_full = 1'b0;
    budget = 0;
    while (rec_owner.size() < 1 && budget < 50) begin tick(); budget++; end
    if (rec_owner.size() < 1) fail_now("t032_end_timeout");
    else begin
      chk("t032_owner", rec_owner[0], 1);
      chk("t032_len", rec_len[0], 4);
    end
    quiesce();

    // Owner 3 withdraws after one word; next grant goes to index 0.
    repeat (3) push_word(3);
    repeat (2) push_word(0);
    repeat (2) push_word(1);
    en = 4'b1000;
    budget = 0;
    while (!(m_busy && m_owner == 3 && cur_len == 1) && budget < 50) begin tick(); budget++; end
    if (budget >= 50) fail_now("t033_timeout");
    en = 4'b0011;
    budget = 0;
    while (rec_owner.size() < 2 && budget < 50) begin tick(); budget++; end
    if (rec_owner.size() < 2) fail_now("t033_end_timeout");
    else begin
      chk("t033_owner0", rec_owner[0], 3);
      chk("t033_len0", rec_len[0], 1);
      chk("t033_owner1", rec_owner[1], 0);
    end
    quiesce();

    // Reset asserted during the third word of a burst.
    repeat (6) push_word(2);
    en = 4'b0100;
    budget = 0;
    while (!(m_busy && m_owner == 2 && cur_len == 2) && budget < 50) begin tick(); budget++; end
    if (budget >= 50) fail_now("t034_timeout");
    drive();
    #2;
    chk("t034_pre_rst_wr", fifo_wr, 1);
    rst = 1'b1;
    #1;
    chk("t034_async_wr", fifo_wr, 0);
    chk("t034_async_ready", req_ready, 0);
    chk("t034_async_busy", busy, 0);
    @(posedge clk);
    #1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) push_word(0);
    repeat (2) push_word(1);
    en = 4'b0111;
    budget = 0;
    while (rec_owner.size() < 1 && budget < 50) begin tick(); budget++; end
    if (rec_owner.size() < 1) fail_now("t034_end_timeout");
    else chk("t034_first_owner", rec_owner[0], 0);
    quiesce();

    // 1000 random cycles with random traffic, withdrawals and fifo_full.
    for (int c = 0; c < 1000; c++) begin
      if ($urandom_range(0, 1) == 0) begin
        int r;
        r = $urandom_range(0, NREQ - 1);
        if (src_q[r].size() < 8) push_word(r);
      end
      for (int i = 0; i < NREQ; i++) en[i] = ($urandom_range(0, 4) != 0);
      fifo_full = ($urandom_range(0, 3) == 0);
      tick();
    end
    en        = '1;
    fifo_full = 1'b0;
    budget    = 0;
    all_empty = 0;
    while (!all_empty && budget < 400) begin
      tick();
      budget++;
      all_empty = 1;
      for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) all_empty = 0;
    end
    if (!all_empty) fail_now("t035_drain_timeout");
    repeat (3) tick();
    for (int i = 0; i < NREQ; i++) chk($sformatf("t035_left%0d", i), exp_q[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time guard so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The module SHALL have parameter NREQ, default 4, giving the number of write requesters (range 2..8).
REQ-002 The module SHALL have parameter DW, default 8, giving the data width, matching the FIFO data_in width.
REQ-003 The module SHALL have parameter MAX_BURST, default 4, giving the maximum number of words per grant (range 1..16).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 The module SHALL have port req_valid, input, NREQ bits: bit i means requester i presents a word.
REQ-007 The module SHALL have port req_data, input, NREQ*DW bits: word of requester i in bits [i*DW +: DW].
REQ-008 The module SHALL have port req_ready, output, NREQ bits: bit i means the word of requester i is accepted this cycle.
REQ-009 The module SHALL have port fifo_wr, output, 1 bit, driving the FIFO wr input.
REQ-010 The module SHALL have port fifo_data_in, output, DW bits, driving the FIFO data_in input.
REQ-011 The module SHALL have port fifo_full, input, 1 bit, taken from the FIFO full output.
REQ-012 The module SHALL have port grant_id, output, $clog2(NREQ) bits: index of the current owner.
REQ-013 The module SHALL have port busy, output, 1 bit: high while in state BURST.

Function
REQ-014 The FSM SHALL have two states: IDLE and BURST.
REQ-015 In IDLE with any req_valid bit high, the arbiter SHALL latch as owner the first valid index found round-robin starting at last_owner+1 (mod NREQ), and enter BURST on the next edge.
REQ-016 In IDLE, req_ready SHALL be all-zero and fifo_wr SHALL be 0, so no transfer occurs in the arbitration cycle.
REQ-017 In BURST, req_ready[owner] SHALL equal ~fifo_full combinationally, and all other req_ready bits SHALL be 0.
REQ-018 A transfer SHALL occur when req_valid[owner] & req_ready[owner]; in that cycle fifo_wr=1 and fifo_data_in=req_data[owner], with zero latency.
REQ-019 When no transfer occurs, fifo_wr SHALL be 0 and fifo_data_in SHALL hold its last driven value (registered mux select; no X).
REQ-020 A burst counter SHALL increment on each transfer; the transfer that brings it to MAX_BURST SHALL return the FSM to IDLE on the next edge.
REQ-021 If req_valid[owner] is low in any BURST cycle, the FSM SHALL return to IDLE on the next edge; words already sent are kept.
REQ-022 While fifo_full is high in BURST, the FSM SHALL hold BURST and hold the counter, with no timeout.
REQ-023 On every BURST->IDLE transition, last_owner SHALL be updated to the owner and the counter cleared.
REQ-024 A single continuously-valid requester SHALL see exactly one idle bubble cycle between consecutive bursts.
REQ-025 grant_id SHALL show the owner in BURST and the last owner in IDLE.

Reset
REQ-026 While rst is high: state=IDLE, counter=0, last_owner=NREQ-1 (so index 0 wins first), grant_id=0, busy=0, fifo_wr=0, fifo_data_in=0, req_ready=0.
REQ-027 Reset asserted mid-burst SHALL force fifo_wr and req_ready low immediately, with no partial transfer.

Structure
REQ-028 A shared package fifo_arb_pkg SHALL hold the state enum type (IDLE, BURST) and the default constants for NREQ, DW and MAX_BURST.
REQ-029 The round-robin priority search SHALL be one sub-module, rr_pick (inputs: request vector, start index; outputs: found, index), purely combinational.

Verification
REQ-030 Reset then req_valid=4'b1111, fifo_full=0 -> owner order 0,1,2,3,0; each burst exactly 4 fifo_wr pulses; one IDLE cycle between bursts.
REQ-031 Only req 2 valid, 10 words -> bursts of 4,4,2; grant_id=2 throughout; bubble after each full burst.
REQ-032 Owner 1 mid-burst, fifo_full high for 3 cycles after word 2 -> req_ready[1]=0 and fifo_wr=0 for 3 cycles; remaining 2 words then complete; total 4.
REQ-033 Owner 3 drops req_valid after 1 word -> IDLE next cycle; last_owner=3; next grant goes to the lowest valid index from 0.
REQ-034 rst asserted during word 3 of a burst -> fifo_wr=0 asynchronously; after release the first grant goes to index 0.
REQ-035 A scoreboard SHALL compare the FIFO data_out stream against per-requester queues (no loss, no duplication, and in-order per requester) over 1000 random cycles with random fifo_full.
